// File: rtl/fetch_controller.sv
// Instruction fetch controller: IDLE/RUN/HALT sequencing, redirect,
// valid/ready output stage and saturating fetch/stall counters.
`ifndef INSTRUCTION_WIDTH
`define INSTRUCTION_WIDTH 32
`endif

module fetch_controller #(
  parameter int          ADDR_WIDTH = 10,
  parameter int          DATA_WIDTH = `INSTRUCTION_WIDTH,
  parameter int unsigned RESET_PC   = 0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  halt_req,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [DATA_WIDTH-1:0] inst_out,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  output logic [1:0]            state,
  output logic [31:0]           fetch_count,
  output logic [31:0]           stall_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] RST_PC =
    ADDR_WIDTH'(RESET_PC);

  state_t                state_q;
  logic                  out_valid;
  logic [ADDR_WIDTH-1:0] out_pc;
  logic [ADDR_WIDTH-1:0] halt_pc;

  logic                  run;
  logic                  accept;
  logic                  stall;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [ADDR_WIDTH-1:0] resume;

  assign state      = state_q;
  assign inst_pc    = out_pc;
  assign inst_out   = mem_rdata;
  assign inst_valid = out_valid & ~redirect_valid;

  assign run    = (state_q == RUN);
  assign accept = run & inst_valid & inst_ready;
  assign stall  = run & inst_valid & ~inst_ready;
  assign pc_inc = out_pc + ADDR_WIDTH'(1);
  assign resume = accept ? pc_inc : out_pc;

  // mem_addr is always the address that lands in out_pc next edge
  always_comb begin
    mem_addr = RST_PC;
    case (state_q)
      IDLE: mem_addr = RST_PC;
      RUN: begin
        if (redirect_valid)
          mem_addr = redirect_pc;
        else if (halt_req)
          mem_addr = resume;
        else
          mem_addr = resume;
      end
      HALT: begin
        if (redirect_valid)
          mem_addr = redirect_pc;
        else
          mem_addr = halt_pc;
      end
      default: mem_addr = RST_PC;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      out_pc    <= RST_PC;
      out_valid <= 1'b0;
      halt_pc   <= RST_PC;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= RUN;
            out_pc    <= RST_PC;
            out_valid <= 1'b1;
          end
        end
        RUN: begin
          if (redirect_valid) begin
            out_pc    <= redirect_pc;
            out_valid <= 1'b1;
          end else if (halt_req) begin
            halt_pc   <= resume;
            out_valid <= 1'b0;
            state_q   <= HALT;
          end else begin
            out_pc <= resume;
          end
        end
        HALT: begin
          if (redirect_valid)
            halt_pc <= redirect_pc;
          if (start) begin
            out_pc    <= mem_addr;
            out_valid <= 1'b1;
            state_q   <= RUN;
          end
        end
        default: begin
          state_q   <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (accept && fetch_count != '1)
        fetch_count <= fetch_count + 32'd1;
      if (stall && stall_count != '1)
        stall_count <= stall_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller with a one-cycle-latency
// instruction memory holding word[i] = i.
`timescale 1ns/1ps

module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        halt_req = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [9:0]  redirect_pc = '0;
  logic [9:0]  mem_addr;
  logic [31:0] mem_rdata = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_out;
  logic [9:0]  inst_pc;
  logic [1:0]  state;
  logic [31:0] fetch_count;
  logic [31:0] stall_count;

  int errors = 0;
  int checks = 0;

  fetch_controller #(
    .ADDR_WIDTH(10),
    .DATA_WIDTH(32),
    .RESET_PC(0)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .start(start),
    .halt_req(halt_req),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .mem_addr(mem_addr),
    .mem_rdata(mem_rdata),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .inst_out(inst_out),
    .inst_pc(inst_pc),
    .state(state),
    .fetch_count(fetch_count),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    mem_rdata <= {22'd0, mem_addr};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_start();
    rstn = 1'b0;
    start = 1'b0;
    halt_req = 1'b0;
    redirect_valid = 1'b0;
    inst_ready = 1'b1;
    tick();
    tick();
    rstn = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic advance(input int n);
    inst_ready = 1'b1;
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if (state !== 2'd0) begin
      errors++;
      $display("FAIL rst_state got=%0d exp=0", state);
    end
    checks++;
    if (inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_valid got=%b exp=0", inst_valid);
    end
    checks++;
    if (mem_addr !== 10'd0) begin
      errors++;
      $display("FAIL rst_addr got=%h exp=0", mem_addr);
    end
    checks++;
    if (fetch_count !== 0 || stall_count !== 0) begin
      errors++;
      $display("FAIL rst_cnt got=%0d/%0d exp=0/0",
               fetch_count, stall_count);
    end
    tick();
    rstn = 1'b1;
    halt_req = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 10'h55;
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (state !== 2'd0 || mem_addr !== 10'd0) begin
      errors++;
      $display("FAIL idle_hold got=%0d/%h exp=0/0",
               state, mem_addr);
    end
    halt_req = 1'b0;
    redirect_valid = 1'b0;
  endtask

  task automatic test_sequential();
    reset_start();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 10'(i) ||
          inst_out !== 32'(i)) begin
        errors++;
        $display("FAIL seq v=%b pc=%h out=%h exp pc=%h",
                 inst_valid, inst_pc, inst_out, 10'(i));
      end
      tick();
    end
    checks++;
    if (fetch_count !== 32'd6) begin
      errors++;
      $display("FAIL seq_cnt got=%0d exp=6", fetch_count);
    end
  endtask

  task automatic test_stall();
    reset_start();
    advance(5);
    inst_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 10'd5 ||
          mem_addr !== 10'd5) begin
        errors++;
        $display("FAIL stall v=%b pc=%h addr=%h exp 1/5/5",
                 inst_valid, inst_pc, mem_addr);
      end
      tick();
    end
    inst_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (inst_pc !== 10'd5 || inst_out !== 32'd5 ||
        stall_count !== 32'd3) begin
      errors++;
      $display("FAIL stall_end pc=%h out=%h sc=%0d exp 5/5/3",
               inst_pc, inst_out, stall_count);
    end
    tick();
    @(negedge clk);
    checks++;
    if (inst_pc !== 10'd6 || inst_out !== 32'd6 ||
        fetch_count !== 32'd6) begin
      errors++;
      $display("FAIL stall_next pc=%h out=%h fc=%0d exp 6/6/6",
               inst_pc, inst_out, fetch_count);
    end
  endtask

  task automatic test_redirect();
    reset_start();
    advance(7);
    redirect_valid = 1'b1;
    redirect_pc = 10'h3F0;
    @(negedge clk);
    checks++;
    if (inst_valid !== 1'b0 || inst_pc !== 10'd7 ||
        mem_addr !== 10'h3F0) begin
      errors++;
      $display("FAIL redir_sq v=%b pc=%h addr=%h exp 0/7/3f0",
               inst_valid, inst_pc, mem_addr);
    end
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (fetch_count !== 32'd7) begin
      errors++;
      $display("FAIL redir_cnt got=%0d exp=7", fetch_count);
    end
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 10'h3F0 ||
        inst_out !== 32'h3F0) begin
      errors++;
      $display("FAIL redir_tgt v=%b pc=%h out=%h exp 1/3f0",
               inst_valid, inst_pc, inst_out);
    end
  endtask

  task automatic test_wrap();
    logic [9:0] exp_pc [3];
    exp_pc[0] = 10'h3FF;
    exp_pc[1] = 10'h000;
    exp_pc[2] = 10'h001;
    inst_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 10'h3FF;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== exp_pc[i] ||
          inst_out !== {22'd0, exp_pc[i]}) begin
        errors++;
        $display("FAIL wrap v=%b pc=%h out=%h exp pc=%h",
                 inst_valid, inst_pc, inst_out, exp_pc[i]);
      end
      tick();
    end
  endtask

  task automatic test_halt();
    reset_start();
    advance(9);
    halt_req = 1'b1;
    @(negedge clk);
    checks++;
    if (inst_valid !== 1'b1 || mem_addr !== 10'd10) begin
      errors++;
      $display("FAIL halt_acc v=%b addr=%h exp 1/00a",
               inst_valid, mem_addr);
    end
    tick();
    halt_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (state !== 2'd2 || inst_valid !== 1'b0 ||
          mem_addr !== 10'd10) begin
        errors++;
        $display("FAIL halt_hold st=%0d v=%b addr=%h exp 2/0/00a",
                 state, inst_valid, mem_addr);
      end
      tick();
    end
    checks++;
    if (fetch_count !== 32'd10) begin
      errors++;
      $display("FAIL halt_cnt got=%0d exp=10", fetch_count);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (state !== 2'd1 || inst_pc !== 10'd10 ||
        inst_out !== 32'd10) begin
      errors++;
      $display("FAIL resume st=%0d pc=%h out=%h exp 1/00a",
               state, inst_pc, inst_out);
    end
    // halt while stalled keeps the unaccepted pc
    inst_ready = 1'b0;
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    @(negedge clk);
    checks++;
    if (state !== 2'd2 || mem_addr !== 10'd10) begin
      errors++;
      $display("FAIL halt_stall st=%0d addr=%h exp 2/00a",
               state, mem_addr);
    end
    redirect_valid = 1'b1;
    redirect_pc = 10'h100;
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (state !== 2'd2 || mem_addr !== 10'h100) begin
      errors++;
      $display("FAIL halt_redir st=%0d addr=%h exp 2/100",
               state, mem_addr);
    end
    inst_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (inst_pc !== 10'h100 || inst_out !== 32'h100) begin
      errors++;
      $display("FAIL halt_redir_go pc=%h out=%h exp 100",
               inst_pc, inst_out);
    end
    // redirect beats halt_req in RUN
    halt_req = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 10'h020;
    tick();
    halt_req = 1'b0;
    redirect_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (state !== 2'd1 || inst_pc !== 10'h020) begin
      errors++;
      $display("FAIL redir_over_halt st=%0d pc=%h exp 1/020",
               state, inst_pc);
    end
  endtask

  task automatic test_reset_mid();
    reset_start();
    advance(20);
    inst_ready = 1'b0;
    tick();
    tick();
    rstn = 1'b0;
    #1;
    checks++;
    if (inst_valid !== 1'b0 || state !== 2'd0) begin
      errors++;
      $display("FAIL rst_mid v=%b st=%0d exp 0/0",
               inst_valid, state);
    end
    checks++;
    if (fetch_count !== 0 || stall_count !== 0) begin
      errors++;
      $display("FAIL rst_mid_cnt got=%0d/%0d exp 0/0",
               fetch_count, stall_count);
    end
    tick();
    rstn = 1'b1;
    inst_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 10'd0 ||
        fetch_count !== 0) begin
      errors++;
      $display("FAIL rst_restart v=%b pc=%h fc=%0d exp 1/0/0",
               inst_valid, inst_pc, fetch_count);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_wrap();
    test_halt();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, meaning the instruction word-address width, matching the instruction memory depth.
REQ-002 SHALL have parameter DATA_WIDTH, default `INSTRUCTION_WIDTH (32), meaning the instruction width.
REQ-003 SHALL have parameter RESET_PC, default 0, meaning the first word address fetched after start.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rstn, input, 1, reset: asynchronous assertion, active-low.
REQ-006 SHALL have port start, input, 1, begin or resume fetching from IDLE or HALT.
REQ-007 SHALL have port halt_req, input, 1, stop fetching.
REQ-008 SHALL have port redirect_valid, input, 1, flush and restart fetch at redirect_pc.
REQ-009 SHALL have port redirect_pc, input, ADDR_WIDTH, the redirect target word address.
REQ-010 SHALL have port mem_addr, output, ADDR_WIDTH, the instruction memory read address; memory data is returned one cycle later.
REQ-011 SHALL have port mem_rdata, input, DATA_WIDTH, the instruction memory read data.
REQ-012 SHALL have port inst_valid, output, 1, inst_out and inst_pc hold a valid instruction.
REQ-013 SHALL have port inst_ready, input, 1, downstream accepts the instruction when inst_valid and inst_ready are both 1.
REQ-014 SHALL have port inst_out, output, DATA_WIDTH, the instruction, equal to mem_rdata.
REQ-015 SHALL have port inst_pc, output, ADDR_WIDTH, the address of inst_out.
REQ-016 SHALL have port state, output, 2, the state encoding: IDLE=0, RUN=1, HALT=2.
REQ-017 SHALL have port fetch_count, output, 32, the number of accepted instructions, saturating.
REQ-018 SHALL have port stall_count, output, 32, the number of cycles with inst_valid=1 and inst_ready=0, saturating.

Function
REQ-019 SHALL hold registers out_pc, out_valid, halt_pc and state; mem_addr is combinational, and its value becomes out_pc at the next edge.
REQ-020 SHALL drive inst_pc=out_pc and inst_out=mem_rdata.
REQ-021 SHALL drive inst_valid = out_valid AND NOT redirect_valid; a redirect squashes the presented instruction in the same cycle.
REQ-022 IDLE: inst_valid=0 and mem_addr=RESET_PC; on start, go to RUN with out_pc<=RESET_PC and out_valid<=1.
REQ-023 RUN, evaluated in priority order each cycle:
- redirect_valid: mem_addr=redirect_pc, out_pc<=redirect_pc, out_valid<=1; this also overrides halt_req.
- halt_req: mem_addr=resume address, halt_pc<=resume address, out_valid<=0, go to HALT. The resume address is out_pc+1 if the presented instruction is accepted this cycle, else out_pc.
- inst_valid and NOT inst_ready (stall): mem_addr=out_pc, re-issued, with out_pc held.
- accept: mem_addr=out_pc+1, out_pc advances.
REQ-024 SHALL perform all PC increments modulo 2^ADDR_WIDTH; (2^ADDR_WIDTH)-1 followed by an accept yields 0, with no flag and no stall.
REQ-025 HALT: inst_valid=0 and mem_addr=halt_pc.
- redirect_valid loads halt_pc<=redirect_pc and stays in HALT.
- start, without redirect, goes to RUN with out_pc<=halt_pc and out_valid<=1.
- If redirect and start occur together, out_pc<=redirect_pc.
REQ-026 SHALL ignore start while in RUN, and SHALL ignore halt_req and redirect_valid while in IDLE.
REQ-027 SHALL increment fetch_count on each accept, including an accept in a halt_req cycle, and SHALL hold it at 32'hFFFFFFFF.
REQ-028 SHALL increment stall_count on each stall cycle, and SHALL hold it at 32'hFFFFFFFF.
REQ-029 SHALL never present the same address twice as accepted, and SHALL never skip an address except on redirect.
REQ-030 Encoding 3 of state is unreachable; if entered, the block SHALL go to IDLE on the next edge.

Reset
REQ-031 While rstn=0 the block SHALL hold state=IDLE, out_pc=RESET_PC, out_valid=0, halt_pc=RESET_PC, fetch_count=0, stall_count=0; hence inst_valid=0 and mem_addr=RESET_PC.
REQ-032 Reset asserted mid-RUN SHALL clear inst_valid immediately, without waiting for a clock edge, and no accept SHALL be counted in that cycle.
REQ-033 After rstn deasserts, the block SHALL stay in IDLE until start=1.

Verification
REQ-034 Reset, then start=1 for one cycle, with inst_ready=1 held and memory word[i]=i -> from cycle 1 onward, inst_pc/inst_out sequence 0/0, 1/1, 2/2 ..., with one instruction per cycle.
REQ-035 RUN at pc=5, inst_ready=0 for 3 cycles -> inst_pc=5 held for 4 cycles and mem_addr=5 throughout; stall_count+=3; then pc 6 follows with no gap.
REQ-036 redirect_valid=1 with redirect_pc=0x3F0 while pc=7 is presented with inst_ready=1 -> inst_valid=0 in that cycle, fetch_count unchanged; next cycle inst_pc=0x3F0.
REQ-037 halt_req while pc=9 is accepted -> state=HALT, halt_pc=10, inst_valid=0; start=1 three cycles later -> next cycle inst_pc=10.
REQ-038 ADDR_WIDTH=10, redirect to 0x3FF, inst_ready=1 -> inst_pc sequence 0x3FF, 0x000, 0x001.
REQ-039 rstn pulsed low mid-stall at pc=20 -> inst_valid=0, counters=0, state=IDLE; after rstn returns high, start=1 -> first inst_pc=RESET_PC.
